// File: rtl/cache_ctrl.sv
// 2-way set-associative, write-through / no-write-allocate data cache between MEM stage and SRAM controller.
// Optional hit/miss statistics counters are enabled with `define CACHE_STATS_EN.
module cache_ctrl #(
    parameter int SET_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [15:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        CACHE_NOT_READY,
    output logic        sram_r_en,
    output logic        sram_w_en,
    output logic [15:0] sram_address,
    output logic [31:0] sram_writeData,
    input  logic [31:0] sram_readData,
    input  logic        SRAM_NOT_READY
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);
    localparam int SETS     = 1 << SET_BITS;
    localparam int TAG_BITS = 16 - SET_BITS;

    // state | meaning
    // IDLE  | serve hits, accept new requests
    // FILL  | read miss, waiting on SRAM word
    // WRITE | write-through to SRAM in progress
    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;
    state_t state, state_nx;

    logic [SETS-1:0]     valid0, valid1, lru;
    logic [TAG_BITS-1:0] tag0  [SETS];
    logic [TAG_BITS-1:0] tag1  [SETS];
    logic [31:0]         data0 [SETS];
    logic [31:0]         data1 [SETS];

    logic [SET_BITS-1:0] idx;
    logic [TAG_BITS-1:0] tag_in;
    logic                hit0, hit1, hit;
    logic                rd_hit, fill_done, write_done;

    assign idx    = address[SET_BITS-1:0];
    assign tag_in = address[15:SET_BITS];
    assign hit0   = valid0[idx] && (tag0[idx] == tag_in);
    // way0 wins if both ways ever match
    assign hit1   = valid1[idx] && (tag1[idx] == tag_in) && !hit0;
    assign hit    = hit0 || hit1;

    assign rd_hit     = (state == IDLE) && MEM_R_EN && hit;
    assign fill_done  = (state == FILL) && !SRAM_NOT_READY;
    assign write_done = (state == WRITE) && !SRAM_NOT_READY;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx        = state;
        readData        = 32'h0;
        CACHE_NOT_READY = 1'b0;
        sram_r_en       = 1'b0;
        sram_w_en       = 1'b0;
        sram_address    = 16'h0;
        sram_writeData  = 32'h0;
        // outputs are forced low while reset is held, even mid-transaction
        if (rst) begin
            sram_address   = address;
            sram_writeData = writeData;
            case (state)
                IDLE: begin
                    if (MEM_R_EN) begin
                        if (hit) begin
                            readData = hit0 ? data0[idx] : data1[idx];
                        end else begin
                            CACHE_NOT_READY = 1'b1;
                            state_nx        = FILL;
                        end
                    end else if (MEM_W_EN) begin
                        CACHE_NOT_READY = 1'b1;
                        state_nx        = WRITE;
                    end
                end
                FILL: begin
                    sram_r_en = 1'b1;
                    if (SRAM_NOT_READY) begin
                        CACHE_NOT_READY = 1'b1;
                    end else begin
                        readData = sram_readData;
                        state_nx = IDLE;
                    end
                end
                WRITE: begin
                    sram_w_en = 1'b1;
                    if (SRAM_NOT_READY) CACHE_NOT_READY = 1'b1;
                    else                state_nx        = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid0 <= '0;
            valid1 <= '0;
            lru    <= '0;
        end else begin
            if (rd_hit) begin
                lru[idx] <= hit0;
            end else if (fill_done) begin
                if (lru[idx]) valid1[idx] <= 1'b1;
                else          valid0[idx] <= 1'b1;
                lru[idx] <= !lru[idx];
            end else if (write_done && hit) begin
                lru[idx] <= hit0;
            end
        end
    end

    // tag/data storage carries no reset
    always_ff @(posedge clk) begin
        if (fill_done) begin
            if (lru[idx]) begin
                tag1[idx]  <= tag_in;
                data1[idx] <= sram_readData;
            end else begin
                tag0[idx]  <= tag_in;
                data0[idx] <= sram_readData;
            end
        end else if (write_done) begin
            if (hit0)      data0[idx] <= writeData;
            else if (hit1) data1[idx] <= writeData;
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= 16'h0;
            miss_count <= 16'h0;
        end else begin
            if ((rd_hit || (write_done && hit)) && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'h1;
            if ((fill_done || (write_done && !hit)) && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'h1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: driver pushes expected responses, monitor pops on request completion.
module tb_cache_ctrl;
    localparam int WAIT       = 5;        // SRAM busy cycles after enable first seen
    localparam int MISS_STALL = WAIT + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_R_EN, MEM_W_EN;
    logic [15:0] address;
    logic [31:0] writeData, readData;
    logic        CACHE_NOT_READY, sram_r_en, sram_w_en;
    logic [15:0] sram_address;
    logic [31:0] sram_writeData, sram_readData;
    logic        SRAM_NOT_READY;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    cache_ctrl #(.SET_BITS(6)) dut (
        .clk(clk), .rst(rst),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .address(address), .writeData(writeData), .readData(readData),
        .CACHE_NOT_READY(CACHE_NOT_READY),
        .sram_r_en(sram_r_en), .sram_w_en(sram_w_en),
        .sram_address(sram_address), .sram_writeData(sram_writeData),
        .sram_readData(sram_readData), .SRAM_NOT_READY(SRAM_NOT_READY)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    // SRAM controller model: busy for WAIT cycles from the first enabled cycle
    logic [31:0] mem [65536];
    int          busy_cnt;
    assign SRAM_NOT_READY = (sram_r_en || sram_w_en) && (busy_cnt < WAIT);
    assign sram_readData  = mem[sram_address];

    always @(posedge clk) begin
        if (sram_r_en || sram_w_en) busy_cnt <= busy_cnt + 1;
        else                        busy_cnt <= 0;
        if (sram_w_en && !SRAM_NOT_READY) mem[sram_address] <= sram_writeData;
    end

    typedef struct {
        bit          is_read;
        logic [31:0] data;
        int          stall;
        int          ren;
        int          wen;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: count stall/enable cycles per request, compare on completion
    int stall_c = 0, ren_c = 0, wen_c = 0;
    always @(negedge clk) begin
        if (!rst || !(MEM_R_EN || MEM_W_EN)) begin
            stall_c = 0; ren_c = 0; wen_c = 0;
        end else begin
            if (CACHE_NOT_READY) stall_c++;
            if (sram_r_en) ren_c++;
            if (sram_w_en) wen_c++;
            if (!CACHE_NOT_READY) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_completion: addr %h with empty scoreboard", address);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.is_read) check($sformatf("readData@%h", address), readData, e.data);
                    check($sformatf("stall_cycles@%h", address), stall_c, e.stall);
                    check($sformatf("sram_r_en_cycles@%h", address), ren_c, e.ren);
                    check($sformatf("sram_w_en_cycles@%h", address), wen_c, e.wen);
                end
                stall_c = 0; ren_c = 0; wen_c = 0;
            end
        end
    end

    // called at posedge+1; returns at posedge+1 after completion (back-to-back capable)
    task automatic req(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [31:0] wd, input exp_t e);
        int  n;
        bit  done;
        n = 0; done = 0;
        sb.push_back(e);
        MEM_R_EN = rd; MEM_W_EN = wr; address = a; writeData = wd;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
            if (!CACHE_NOT_READY) done = 1;
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL timeout@%h: still stalled after %0d cycles, expected completion", a, n);
        end
        @(posedge clk); #1;
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    endtask

    task automatic rd_hit(input logic [15:0] a, input logic [31:0] d);
        req(1'b1, 1'b0, a, 32'h0, '{1'b1, d, 0, 0, 0});
    endtask
    task automatic rd_miss(input logic [15:0] a, input logic [31:0] d);
        req(1'b1, 1'b0, a, 32'h0, '{1'b1, d, MISS_STALL, MISS_STALL, 0});
    endtask
    task automatic wr_req(input logic [15:0] a, input logic [31:0] d);
        req(1'b0, 1'b1, a, d, '{1'b0, 32'h0, MISS_STALL, 0, MISS_STALL});
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = {16'hA5A5, i[15:0]};
        mem[16'h0041] = 32'hDEADBEEF;

        rst = 1'b0; MEM_R_EN = 1'b1; MEM_W_EN = 1'b0;
        address = 16'h1234; writeData = 32'h5555AAAA;
        #12;
        check("reset_readData", readData, 32'h0);
        check("reset_not_ready", CACHE_NOT_READY, 1'b0);
        check("reset_sram_r_en", sram_r_en, 1'b0);
        check("reset_sram_w_en", sram_w_en, 1'b0);
        check("reset_sram_address", sram_address, 16'h0);
        check("reset_sram_writeData", sram_writeData, 32'h0);
        MEM_R_EN = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("passthrough_address", sram_address, 16'h1234);

        rd_miss(16'h0041, 32'hDEADBEEF);
        rd_hit (16'h0041, 32'hDEADBEEF);
        rd_miss(16'h0081, 32'hA5A50081);
        rd_miss(16'h00C1, 32'hA5A500C1);   // evicts 0x0041 from way0
        rd_hit (16'h0081, 32'hA5A50081);
        rd_miss(16'h0041, 32'hDEADBEEF);   // evicts 0x00C1
        wr_req (16'h0041, 32'h1234ABCD);
        rd_hit (16'h0041, 32'h1234ABCD);
        wr_req (16'h0300, 32'hCAFEF00D);
        rd_miss(16'h0300, 32'hCAFEF00D);
        req(1'b1, 1'b1, 16'h0300, 32'h11111111, '{1'b1, 32'hCAFEF00D, 0, 0, 0});
        rd_hit (16'h0300, 32'hCAFEF00D);

        // abort a fill with reset
        MEM_R_EN = 1'b1; address = 16'h01C5;
        repeat (3) @(negedge clk);
        check("midfill_sram_r_en", sram_r_en, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("abort_sram_r_en", sram_r_en, 1'b0);
        check("abort_not_ready", CACHE_NOT_READY, 1'b0);
        MEM_R_EN = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        rd_miss(16'h01C5, 32'hA5A501C5);
        rd_miss(16'h0041, 32'h1234ABCD);

        do_reset();
        rd_miss(16'h0010, 32'hA5A50010);
        rd_hit (16'h0010, 32'hA5A50010);
        rd_hit (16'h0010, 32'hA5A50010);
        wr_req (16'h0020, 32'h0BADCAFE);
        rd_miss(16'h0020, 32'h0BADCAFE);
`ifdef CACHE_STATS_EN
        check("hit_count", hit_count, 16'd2);
        check("miss_count", miss_count, 16'd3);
`endif
        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1);
    end
endmodule
